// File: rtl/branch_predictor.sv
// Branch predictor: a table of 2-bit saturating counters indexed by word
// address, with a combinational IF-stage lookup and a MEM-stage update.
// It also keeps saturating counts of resolved branches and mispredictions.
//
// Ports
//   clk              rising-edge clock for all state
//   reset            synchronous, active-high reset
//   if_pc            IF-stage fetch address to look up
//   if_is_branch     IF-stage instruction is a conditional branch
//   predicted        combinational taken prediction for the IF instruction
//   mem_pc           address of the instruction in MEM
//   mem_branch       MEM instruction is a conditional branch
//   mem_taken        resolved outcome of the MEM branch
//   mem_predicted    prediction that was made for the MEM instruction
//   mem_update_en    MEM holds a valid, unstalled, unflushed instruction
//   branch_count     number of resolved conditional branches (saturating)
//   mispredict_count number of mispredicted branches (saturating)
module branch_predictor #(
  parameter int unsigned BHT_INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  input  logic        if_is_branch,
  output logic        predicted,
  input  logic [31:0] mem_pc,
  input  logic        mem_branch,
  input  logic        mem_taken,
  input  logic        mem_predicted,
  input  logic        mem_update_en,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int unsigned ENTRIES   = 1 << BHT_INDEX_BITS;
  localparam logic [1:0]  CTR_RESET = 2'b01;
  localparam logic [1:0]  CTR_MAX   = 2'b11;
  localparam logic [1:0]  CTR_MIN   = 2'b00;
  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  // Table of 2-bit counters; bit 1 of an entry is the taken prediction.
  logic [ENTRIES-1:0][1:0] bht;

  logic [BHT_INDEX_BITS-1:0] lookup_idx;
  logic [BHT_INDEX_BITS-1:0] update_idx;
  logic                      update_ev;
  logic                      mispredict;
  logic [1:0]                ctr_cur;
  logic [1:0]                ctr_next;
  logic [31:0]               branch_count_next;
  logic [31:0]               mispredict_count_next;

  // Only the word-index bits of the PCs select an entry; the rest alias.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, mem_pc};

  assign lookup_idx = if_pc[BHT_INDEX_BITS+1:2];
  assign update_idx = mem_pc[BHT_INDEX_BITS+1:2];
  assign update_ev  = mem_update_en & mem_branch;
  assign mispredict = mem_predicted ^ mem_taken;

  // Lookup reads the registered table, so a same-cycle update to the same
  // entry is seen only from the following cycle.
  assign predicted = if_is_branch & bht[lookup_idx][1];

  // Saturating counter step and statistics for the entry being resolved.
  always_comb begin
    ctr_cur               = bht[update_idx];
    ctr_next              = ctr_cur;
    branch_count_next     = branch_count;
    mispredict_count_next = mispredict_count;
    if (update_ev) begin
      if (mem_taken) begin
        if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + 2'd1;
      end else begin
        if (ctr_cur != CTR_MIN) ctr_next = ctr_cur - 2'd1;
      end
      if (branch_count != COUNT_MAX) branch_count_next = branch_count + 32'd1;
      if (mispredict && (mispredict_count != COUNT_MAX)) begin
        mispredict_count_next = mispredict_count + 32'd1;
      end
    end
  end

  // State update; reset wins over a coincident update event.
  always_ff @(posedge clk) begin
    if (reset) begin
      bht              <= {ENTRIES{CTR_RESET}};
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else begin
      if (update_ev) bht[update_idx] <= ctr_next;
      branch_count     <= branch_count_next;
      mispredict_count <= mispredict_count_next;
    end
  end

endmodule
